key_code_lock: RTL and testbench
================================

Name: key_code_lock

Overview:
- Code-lock controller directly downstream of the 4x4 keypad scanner.
- Consumes the scanner's debounced key-valid flag and 4-bit key code.
- Assembles a NUM_DIGITS-digit entry and compares it with a stored code; supports unlock, code change, and lockout after repeated failures.
- Drives the unlock/alarm indications and the entered digits for the 7-segment display stage.

Parameters:
- NUM_DIGITS, 4, number of digits in a code; buffer width is 4*NUM_DIGITS.
- DEFAULT_CODE, 16'h1234, stored code after reset; one BCD nibble per digit, most significant digit first.
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout (must be at least 1).
- UNLOCK_CYCLES, 500, clk cycles the lock stays open.
- LOCKOUT_CYCLES, 1000, clk cycles of lockout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  debounced key-held flag from the scanner; high while a key is held.
- key_code  input  4  key value; stable whenever key_valid=1. Values 0-9 are digits; 10 = CLR; 11 = ENT; 12 = SET; 13-15 are unused.
- disp_digits  output  4*NUM_DIGITS  entry buffer, newest digit in bits [3:0].
- digit_count  output  $clog2(NUM_DIGITS+1)  number of digits currently entered.
- unlocked  output  1  high while the lock is open, including during code setting.
- setting  output  1  high in SET_ENTRY.
- alarm  output  1  high during lockout.
- fail_count  output  $clog2(MAX_FAILS+1)  consecutive wrong entries.

Behaviour:
- Reset values: disp_digits=0, digit_count=0, unlocked=0, setting=0, alarm=0, fail_count=0, code register=DEFAULT_CODE, state=ENTRY, timer=0.
- Reset edge-detect register: key_valid_d resets to 1. A key already held when reset is released therefore produces no event.
- Key event definition: key_valid=1 and key_valid_d=0 at a clk edge. Exactly one event occurs per press, however long the key is held. key_code is sampled at that same edge.
- Latency: all register and output updates caused by an event take effect at the event edge, so they are visible 1 cycle after key_valid is first sampled high.
- Digit entry rule (ENTRY and SET_ENTRY):
  - Digit key with digit_count<NUM_DIGITS: buffer <= {buffer[4*NUM_DIGITS-5:0], key_code}; digit_count++.
  - Digit key when the buffer is full: ignored.
- Codes 13-15 are ignored in every state.
- ENTRY state:
  - Digit: apply the digit entry rule.
  - CLR: buffer=0, digit_count=0.
  - SET: ignored.
  - ENT with digit_count==NUM_DIGITS and buffer==code: go to UNLOCKED; fail_count=0; timer=UNLOCK_CYCLES-1.
  - ENT otherwise (short or wrong entry): fail_count++. If the new fail_count equals MAX_FAILS, go to LOCKOUT with alarm=1 and timer=LOCKOUT_CYCLES-1.
  - Any ENT clears the buffer and digit_count.
- UNLOCKED state:
  - unlocked=1; timer decrements each cycle.
  - Timer at 0 with no event: go to ENTRY, unlocked=0.
  - CLR: go to ENTRY immediately.
  - SET: go to SET_ENTRY and clear the buffer; the timer stops.
  - Digits and ENT are ignored.
  - An event in the same cycle the timer reaches 0 takes priority over the timeout.
- SET_ENTRY state:
  - unlocked=1, setting=1; no timeout.
  - Digit: apply the digit entry rule.
  - ENT with digit_count==NUM_DIGITS: code<=buffer, clear the buffer, go to ENTRY (locked).
  - ENT with a short entry: ignored.
  - CLR: abort to ENTRY with the code unchanged and the buffer cleared.
- LOCKOUT state:
  - All keys are ignored; alarm=1; timer decrements.
  - Timer at 0: go to ENTRY with alarm=0 and fail_count=0.
- Timer: width $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)); decrements by 1 and never underflows.
- Reset mid-operation: immediate return to all reset values. A code changed via SET reverts to DEFAULT_CODE.

Decomposition:
- Package key_lock_pkg holds:
  - key constants KEY_CLR=4'd10, KEY_ENT=4'd11, KEY_SET=4'd12;
  - state encoding ST_ENTRY, ST_UNLOCKED, ST_SET_ENTRY, ST_LOCKOUT.
- One sub-module, key_event_detect: registers key_valid and outputs a one-cycle key_event together with the key code. Its key_valid_d register resets to 1.
- The top level contains the FSM, entry buffer, code register, fail counter and timer.

Test Plan:
- Correct code: with UNLOCK_CYCLES=20, press 1,2,3,4,ENT → disp_digits=16'h1234 before ENT; after ENT unlocked=1 and fail_count=0; unlocked=0 exactly 20 cycles later.
- Lockout: with MAX_FAILS=3 and LOCKOUT_CYCLES=40, enter 1,2,3,5,ENT three times → fail_count goes 1, 2, then alarm=1. A correct 1,2,3,4,ENT during lockout has no effect. After 40 cycles alarm=0 and fail_count=0.
- Short entry and overflow: press 7,ENT → fail_count=1. Press 9,8,7,6,5 → disp_digits=16'h9876, digit_count=4 (5th digit ignored). CLR → disp_digits=0, digit_count=0.
- Code change:
  - Unlock, then press SET,5,6,7,8,ENT → setting pulses high during entry, then the block is locked.
  - Entering 1,2,3,4,ENT then fails; entering 5,6,7,8,ENT unlocks.
  - Repeat the sequence with CLR instead of ENT at the end → the code stays 1234.
- Key hold and reset: key_valid held high for 100 cycles with code 3 → exactly one digit accepted. Assert rst while key_valid=1 mid-entry → all outputs 0, and no event after release until key_valid toggles low and then high again.

Source files
------------

// File: rtl/key_lock_pkg.sv
// rtl/key_lock_pkg.sv - shared key codes, FSM state encoding and key helpers for the code lock
package key_lock_pkg;

    localparam logic [3:0] KEY_CLR = 4'd10;
    localparam logic [3:0] KEY_ENT = 4'd11;
    localparam logic [3:0] KEY_SET = 4'd12;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_UNLOCKED,
        ST_SET_ENTRY,
        ST_LOCKOUT
    } state_t;

    // Keys 0-9 are digits; everything above is a command or unused.
    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/key_event_detect.sv
// rtl/key_event_detect.sv - turns the scanner's key-held level into a one-cycle press event
module key_event_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_event,
    output logic [3:0] event_code
);

    logic key_valid_d;

    // Previous key_valid level; resets high so a key held through reset is not an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_d <= 1'b1;
        end else begin
            key_valid_d <= key_valid;
        end
    end

    assign key_event  = key_valid & ~key_valid_d;
    assign event_code = key_code;

endmodule

// File: rtl/key_code_lock.sv
// rtl/key_code_lock.sv - keypad code lock: entry buffer, stored code, fail counter, unlock/lockout timer
module key_code_lock
    import key_lock_pkg::*;
#(
    parameter int                      NUM_DIGITS     = 4,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      UNLOCK_CYCLES  = 500,
    parameter int                      LOCKOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    output logic [4*NUM_DIGITS-1:0]           disp_digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              unlocked,
    output logic                              setting,
    output logic                              alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count
);

    localparam int DW   = 4 * NUM_DIGITS;
    localparam int CW   = $clog2(NUM_DIGITS + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic          key_event;
    logic [3:0]    event_code;
    logic [DW-1:0] code_reg;
    logic [TW-1:0] timer;
    state_t        state;
    logic          buf_full;
    logic [DW-1:0] buf_shifted;

    key_event_detect u_event (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_event  (key_event),
        .event_code (event_code)
    );

    // Shift is written as a multiply-free shift/OR so it also holds for a single-digit code.
    assign buf_full    = (digit_count == CW'(NUM_DIGITS));
    assign buf_shifted = (disp_digits << 4) | DW'(event_code);

    // Lock FSM with registered indications; key events act on the edge they are detected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ENTRY;
            disp_digits <= '0;
            digit_count <= '0;
            unlocked    <= 1'b0;
            setting     <= 1'b0;
            alarm       <= 1'b0;
            fail_count  <= '0;
            code_reg    <= DEFAULT_CODE;
            timer       <= '0;
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (key_event) begin
                        if (is_digit(event_code)) begin
                            if (!buf_full) begin
                                disp_digits <= buf_shifted;
                                digit_count <= digit_count + CW'(1);
                            end
                        end else if (event_code == KEY_CLR) begin
                            disp_digits <= '0;
                            digit_count <= '0;
                        end else if (event_code == KEY_ENT) begin
                            disp_digits <= '0;
                            digit_count <= '0;
                            if (buf_full && disp_digits == code_reg) begin
                                state      <= ST_UNLOCKED;
                                unlocked   <= 1'b1;
                                fail_count <= '0;
                                timer      <= TW'(UNLOCK_CYCLES - 1);
                            end else begin
                                fail_count <= fail_count + FW'(1);
                                if (fail_count + FW'(1) == FW'(MAX_FAILS)) begin
                                    state <= ST_LOCKOUT;
                                    alarm <= 1'b1;
                                    timer <= TW'(LOCKOUT_CYCLES - 1);
                                end
                            end
                        end
                    end
                end

                ST_UNLOCKED: begin
                    // A key event at the expiry cycle holds the lock open for that cycle.
                    if (key_event && event_code == KEY_CLR) begin
                        state    <= ST_ENTRY;
                        unlocked <= 1'b0;
                    end else if (key_event && event_code == KEY_SET) begin
                        state       <= ST_SET_ENTRY;
                        setting     <= 1'b1;
                        disp_digits <= '0;
                        digit_count <= '0;
                    end else if (!key_event && timer == '0) begin
                        state    <= ST_ENTRY;
                        unlocked <= 1'b0;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end

                ST_SET_ENTRY: begin
                    if (key_event) begin
                        if (is_digit(event_code)) begin
                            if (!buf_full) begin
                                disp_digits <= buf_shifted;
                                digit_count <= digit_count + CW'(1);
                            end
                        end else if ((event_code == KEY_ENT && buf_full) || event_code == KEY_CLR) begin
                            if (event_code == KEY_ENT) begin
                                code_reg <= disp_digits;
                            end
                            state       <= ST_ENTRY;
                            unlocked    <= 1'b0;
                            setting     <= 1'b0;
                            disp_digits <= '0;
                            digit_count <= '0;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= ST_ENTRY;
                        alarm      <= 1'b0;
                        fail_count <= '0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: state <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_key_code_lock.sv
// tb/tb_key_code_lock.sv - self-checking bench for key_code_lock with vector table, directed sequences and random model check
module tb_key_code_lock;

    localparam int UNLOCK  = 20;
    localparam int LOCKOUT = 40;
    localparam int MAXF    = 3;

    // Abstract lock modes of the reference model.
    localparam int LOCKED = 0;
    localparam int OPEN   = 1;
    localparam int PROG   = 2;
    localparam int JAM    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] disp_digits;
    logic [2:0]  digit_count;
    logic        unlocked;
    logic        setting;
    logic        alarm;
    logic [1:0]  fail_count;

    int n_cmp = 0;
    int n_bad = 0;

    key_code_lock #(
        .NUM_DIGITS     (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAILS      (MAXF),
        .UNLOCK_CYCLES  (UNLOCK),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .disp_digits (disp_digits),
        .digit_count (digit_count),
        .unlocked    (unlocked),
        .setting     (setting),
        .alarm       (alarm),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_q[$];
    int m_code;
    int m_mode;
    int m_fails;
    int m_edge;
    int m_deadline;
    bit m_prev;

    function automatic int pack_q();
        int v = 0;
        foreach (m_q[i]) v = (v << 4) | m_q[i];
        return v;
    endfunction

    task automatic model_edge(input logic v, input logic [3:0] c, input logic r);
        bit ev;
        if (r) begin
            m_q.delete();
            m_code = 'h1234;
            m_mode = LOCKED;
            m_fails = 0;
            m_prev = 1'b1;
            m_edge = 0;
            m_deadline = 0;
            return;
        end
        ev = v && !m_prev;
        m_prev = v;
        m_edge++;
        case (m_mode)
            LOCKED: if (ev) begin
                if (c < 10) begin
                    if (m_q.size() < 4) m_q.push_back(int'(c));
                end else if (c == 10) begin
                    m_q.delete();
                end else if (c == 11) begin
                    if (m_q.size() == 4 && pack_q() == m_code) begin
                        m_mode = OPEN;
                        m_fails = 0;
                        m_deadline = m_edge + UNLOCK;
                    end else begin
                        m_fails++;
                        if (m_fails == MAXF) begin
                            m_mode = JAM;
                            m_deadline = m_edge + LOCKOUT;
                        end
                    end
                    m_q.delete();
                end
            end
            OPEN: begin
                if (ev && c == 10) m_mode = LOCKED;
                else if (ev && c == 12) begin
                    m_mode = PROG;
                    m_q.delete();
                end else if (!ev && m_edge >= m_deadline) m_mode = LOCKED;
            end
            PROG: if (ev) begin
                if (c < 10) begin
                    if (m_q.size() < 4) m_q.push_back(int'(c));
                end else if (c == 11 && m_q.size() == 4) begin
                    m_code = pack_q();
                    m_q.delete();
                    m_mode = LOCKED;
                end else if (c == 10) begin
                    m_q.delete();
                    m_mode = LOCKED;
                end
            end
            default: if (m_edge >= m_deadline) begin
                m_mode = LOCKED;
                m_fails = 0;
            end
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic v, input logic [3:0] c, input logic r);
        key_valid = v;
        key_code  = c;
        rst       = r;
        @(posedge clk);
        model_edge(v, c, r);
        #1;
        check("model_disp",    int'(disp_digits), pack_q());
        check("model_count",   int'(digit_count), m_q.size());
        check("model_unlock",  int'(unlocked),    int'(m_mode == OPEN || m_mode == PROG));
        check("model_setting", int'(setting),     int'(m_mode == PROG));
        check("model_alarm",   int'(alarm),       int'(m_mode == JAM));
        check("model_fails",   int'(fail_count),  m_fails);
    endtask

    task automatic press(input logic [3:0] c);
        step(1'b1, c, 1'b0);
        step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic press_code(input logic [15:0] code_val, input logic [3:0] last);
        logic [15:0] cv;
        cv = code_val;
        for (int i = 3; i >= 0; i--) press(cv[4*i +: 4]);
        press(last);
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [15:0] disp;
        logic [2:0]  cnt;
        logic        unl;
        logic        setg;
        logic        alm;
        logic [1:0]  fails;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int ptr;
        int k;
        int hold;
        int gap;
        logic [15:0] mc;

        // ---- reset state ----
        do_reset();
        check("reset_disp",    int'(disp_digits), 0);
        check("reset_count",   int'(digit_count), 0);
        check("reset_unlock",  int'(unlocked),    0);
        check("reset_setting", int'(setting),     0);
        check("reset_alarm",   int'(alarm),       0);
        check("reset_fails",   int'(fail_count),  0);

        // ---- vector table: key press -> outputs after the press ----
        tbl.push_back('{4'd1,  16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd2,  16'h0012, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd3,  16'h0123, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd4,  16'h1234, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd11, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd10, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd7,  16'h0007, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'd11, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd9,  16'h0009, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd8,  16'h0098, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd7,  16'h0987, 3'd3, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd6,  16'h9876, 3'd4, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd5,  16'h9876, 3'd4, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd10, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd14, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd12, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd1,  16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd2,  16'h0012, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd3,  16'h0123, 3'd3, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd5,  16'h1235, 3'd4, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{4'd11, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{4'd1,  16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{4'd2,  16'h0012, 3'd2, 1'b0, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{4'd3,  16'h0123, 3'd3, 1'b0, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{4'd5,  16'h1235, 3'd4, 1'b0, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{4'd11, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 2'd3});
        tbl.push_back('{4'd1,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 2'd3});
        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i].key);
            check("vec_disp",    int'(disp_digits), int'(tbl[i].disp));
            check("vec_count",   int'(digit_count), int'(tbl[i].cnt));
            check("vec_unlock",  int'(unlocked),    int'(tbl[i].unl));
            check("vec_setting", int'(setting),     int'(tbl[i].setg));
            check("vec_alarm",   int'(alarm),       int'(tbl[i].alm));
            check("vec_fails",   int'(fail_count),  int'(tbl[i].fails));
        end

        // ---- unlock window is exactly UNLOCK cycles from the ENT edge ----
        do_reset();
        for (int d = 1; d <= 4; d++) press(4'(d));
        check("pre_ent_disp", int'(disp_digits), 'h1234);
        step(1'b1, 4'd11, 1'b0);
        check("ent_unlock", int'(unlocked), 1);
        check("ent_fails",  int'(fail_count), 0);
        for (int i = 1; i < UNLOCK; i++) step(1'b0, 4'd0, 1'b0);
        check("unlock_last_cycle", int'(unlocked), 1);
        step(1'b0, 4'd0, 1'b0);
        check("unlock_expired", int'(unlocked), 0);

        // ---- lockout: three wrong codes, correct code ignored, exact duration ----
        do_reset();
        press_code(16'h1235, 4'd11);
        check("fail_1", int'(fail_count), 1);
        press_code(16'h1235, 4'd11);
        check("fail_2", int'(fail_count), 2);
        for (int d = 1; d <= 4; d++) press(d == 4 ? 4'd5 : 4'(d));
        step(1'b1, 4'd11, 1'b0);
        check("lockout_alarm", int'(alarm), 1);
        k = 1;
        for (int d = 1; d <= 4; d++) begin
            step(1'b1, 4'(d), 1'b0);
            step(1'b0, 4'(d), 1'b0);
            k += 2;
        end
        step(1'b1, 4'd11, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        k += 2;
        check("lockout_ignores_unlock", int'(unlocked), 0);
        check("lockout_ignores_digits", int'(digit_count), 0);
        while (k < LOCKOUT) begin
            step(1'b0, 4'd0, 1'b0);
            k++;
        end
        check("lockout_last_cycle", int'(alarm), 1);
        step(1'b0, 4'd0, 1'b0);
        check("lockout_expired_alarm", int'(alarm), 0);
        check("lockout_expired_fails", int'(fail_count), 0);

        // ---- code change via SET, then old code fails and new code opens ----
        do_reset();
        press_code(16'h1234, 4'd11);
        press(4'd12);
        check("set_setting", int'(setting), 1);
        check("set_unlocked", int'(unlocked), 1);
        for (int d = 5; d <= 8; d++) press(4'(d));
        check("set_entry_disp", int'(disp_digits), 'h5678);
        check("set_entry_setting", int'(setting), 1);
        press(4'd11);
        check("set_done_setting", int'(setting), 0);
        check("set_done_locked", int'(unlocked), 0);
        press_code(16'h1234, 4'd11);
        check("old_code_fails", int'(fail_count), 1);
        check("old_code_locked", int'(unlocked), 0);
        press_code(16'h5678, 4'd11);
        check("new_code_opens", int'(unlocked), 1);

        // ---- aborted code change keeps the default code ----
        do_reset();
        press_code(16'h1234, 4'd11);
        press(4'd12);
        press_code(16'h5678, 4'd10);
        check("abort_setting", int'(setting), 0);
        check("abort_locked", int'(unlocked), 0);
        press_code(16'h1234, 4'd11);
        check("abort_code_kept", int'(unlocked), 1);

        // ---- long hold gives one digit; reset while held gives no event ----
        do_reset();
        repeat (100) step(1'b1, 4'd3, 1'b0);
        step(1'b0, 4'd3, 1'b0);
        check("hold_count", int'(digit_count), 1);
        check("hold_disp",  int'(disp_digits), 'h3);
        press(4'd2);
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd5, 1'b1);
        step(1'b1, 4'd5, 1'b1);
        check("rst_held_disp",  int'(disp_digits), 0);
        check("rst_held_count", int'(digit_count), 0);
        repeat (5) step(1'b1, 4'd5, 1'b0);
        check("rst_release_no_event", int'(digit_count), 0);
        step(1'b0, 4'd5, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        check("rst_retoggle_count", int'(digit_count), 1);
        check("rst_retoggle_disp",  int'(disp_digits), 'h5);

        // ---- random presses, biased toward the stored code ----
        do_reset();
        ptr = 0;
        repeat (2500) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
                ptr = 0;
            end
            mc = m_code[15:0];
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 15);
            end else begin
                k = (ptr < 4) ? int'(mc[4*(3-ptr) +: 4]) : 11;
                ptr = (ptr + 1) % 5;
            end
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 3);
            repeat (hold) step(1'b1, 4'(k), 1'b0);
            repeat (gap) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
